// File: rtl/mar_input_unit_pkg.sv
// Shared constants for the SAP-1 front-panel / memory address path.
package mar_input_unit_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

    localparam logic MODE_PROG = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 3;

endpackage : mar_input_unit_pkg

// File: rtl/mar_sync_chain.sv
// Multi-flop synchroniser for an asynchronous front-panel switch, async active-low clear.
module mar_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic sync_next_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Value the output stage will take on the next edge, used for change detection.
    assign sync_o      = sync_q[SYNC_STAGES-1];
    assign sync_next_c = sync_q[SYNC_STAGES-2];

endmodule : mar_sync_chain

// File: rtl/mar_input_unit.sv
// SAP-1 input/MAR stage: bus-loaded MAR, front-panel address pointer and mode-selected RAM address.
module mar_input_unit
    import mar_input_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES
) (
    input  logic                  CLK,
    input  logic                  CLR_bar,
    input  logic                  L_M_bar,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [ADDR_WIDTH-1:0] programmer_address,
    input  logic                  LD_P_bar,
    input  logic                  INC_P_bar,
    input  logic                  run_or_prog,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  run_mode,
    output logic                  addr_valid,
    output logic                  wrap
);

    logic [ADDR_WIDTH-1:0] mar_q, mar_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  wrap_q, wrap_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  run_mode_sync;
    logic                  run_mode_next_c;

    mar_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_mode_sync (
        .clk         (CLK),
        .rst_n       (CLR_bar),
        .async_i     (run_or_prog),
        .sync_o      (run_mode_sync),
        .sync_next_c (run_mode_next_c)
    );

    // Next-state for MAR, pointer (load beats increment), wrap pulse and settle flag.
    always_comb begin
        mar_d        = mar_q;
        ptr_d        = ptr_q;
        wrap_d       = 1'b0;
        addr_valid_d = (run_mode_next_c == run_mode_sync);

        if (!L_M_bar) begin
            mar_d = bus_address;
        end

        if (!LD_P_bar) begin
            ptr_d = programmer_address;
        end else if (!INC_P_bar) begin
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            wrap_d = (ptr_q == {ADDR_WIDTH{1'b1}});
        end
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            mar_q        <= '0;
            ptr_q        <= '0;
            wrap_q       <= 1'b0;
            addr_valid_q <= 1'b0;
        end else begin
            mar_q        <= mar_d;
            ptr_q        <= ptr_d;
            wrap_q       <= wrap_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign run_mode   = run_mode_sync;
    assign address    = (run_mode_sync == MODE_RUN) ? mar_q : ptr_q;
    assign addr_valid = addr_valid_q;
    assign wrap       = wrap_q;

endmodule : mar_input_unit

// File: tb/tb_mar_input_unit.sv
// Scoreboard bench for mar_input_unit with hand-derived per-cycle expectations.
module tb_mar_input_unit;

    typedef struct packed {
        logic       lm_n;
        logic [3:0] bus;
        logic       ld_n;
        logic       inc_n;
        logic [3:0] pa;
        logic       rop;
    } stim_t;

    typedef struct packed {
        logic [3:0] address;
        logic       run_mode;
        logic       addr_valid;
        logic       wrap;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  e;
    } row_t;

    typedef struct {
        string name;
        obs_t  val;
    } exp_t;

    logic       CLK;
    logic       CLR_bar;
    logic       L_M_bar;
    logic [3:0] bus_address;
    logic [3:0] programmer_address;
    logic       LD_P_bar;
    logic       INC_P_bar;
    logic       run_or_prog;
    logic [3:0] address;
    logic       run_mode;
    logic       addr_valid;
    logic       wrap;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mar_input_unit #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLK                (CLK),
        .CLR_bar            (CLR_bar),
        .L_M_bar            (L_M_bar),
        .bus_address        (bus_address),
        .programmer_address (programmer_address),
        .LD_P_bar           (LD_P_bar),
        .INC_P_bar          (INC_P_bar),
        .run_or_prog        (run_or_prog),
        .address            (address),
        .run_mode           (run_mode),
        .addr_valid         (addr_valid),
        .wrap               (wrap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic obs_t sample();
        obs_t o;
        o.address    = address;
        o.run_mode   = run_mode;
        o.addr_valid = addr_valid;
        o.wrap       = wrap;
        return o;
    endfunction

    function automatic row_t r(input logic lm, input logic [3:0] bus, input logic ld,
                               input logic inc, input logic [3:0] pa, input logic rop,
                               input logic [3:0] a, input logic rm, input logic av,
                               input logic w);
        row_t x;
        x.s = '{lm_n: lm, bus: bus, ld_n: ld, inc_n: inc, pa: pa, rop: rop};
        x.e = '{address: a, run_mode: rm, addr_valid: av, wrap: w};
        return x;
    endfunction

    task automatic drive(input stim_t s);
        L_M_bar            = s.lm_n;
        bus_address        = s.bus;
        LD_P_bar           = s.ld_n;
        INC_P_bar          = s.inc_n;
        programmer_address = s.pa;
        run_or_prog        = s.rop;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        obs_t got;
        CLR_bar = 1'b0;
        drive(r(1, 4'h0, 1, 1, 4'h0, 1, 0, 0, 0, 0).s);
        #3;
        exp_q.push_back('{name: "reset_pre_edge", val: obs_t'({4'h0, 1'b0, 1'b0, 1'b0})});
        got = sample();
        e = exp_q.pop_front();
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
        step();
        CLR_bar = 1'b1;
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h0, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h0, 1, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h0, 1, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("reset_release[%0d]", i), val: rows[i].e});
            step();
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_mar_load();
        row_t rows[$];
        exp_t e;
        obs_t got;
        rows.push_back(r(0, 4'h3, 1, 1, 4'h0, 1, 4'h3, 1, 1, 0));
        rows.push_back(r(1, 4'hC, 1, 1, 4'h0, 1, 4'h3, 1, 1, 0));
        rows.push_back(r(1, 4'hC, 1, 1, 4'h0, 1, 4'h3, 1, 1, 0));
        rows.push_back(r(0, 4'hC, 1, 1, 4'h0, 1, 4'hC, 1, 1, 0));
        rows.push_back(r(1, 4'h6, 1, 1, 4'h0, 1, 4'hC, 1, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("mar_load[%0d]", i), val: rows[i].e});
            step();
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        row_t rows[$];
        exp_t e;
        obs_t got;
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'hC, 1, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 0, 1, 4'hE, 0, 4'hE, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 0, 4'hE, 0, 4'hF, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 0, 4'hE, 0, 4'h0, 0, 1, 1));
        rows.push_back(r(1, 4'h0, 1, 0, 4'hE, 0, 4'h1, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'hE, 0, 4'h1, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 0, 1, 4'h0, 0, 4'h0, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("pointer_wrap[%0d]", i), val: rows[i].e});
            step();
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_load_priority();
        row_t rows[$];
        exp_t e;
        obs_t got;
        rows.push_back(r(1, 4'h0, 0, 1, 4'hF, 0, 4'hF, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 0, 0, 4'h7, 0, 4'h7, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h7, 0, 4'h7, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("load_priority[%0d]", i), val: rows[i].e});
            step();
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_mode_toggle();
        row_t rows[$];
        exp_t e;
        obs_t got;
        rows.push_back(r(0, 4'h5, 0, 1, 4'h9, 0, 4'h9, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h9, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h5, 1, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h5, 1, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h5, 1, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h9, 0, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h9, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("mode_toggle[%0d]", i), val: rows[i].e});
            step();
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_simultaneous();
        row_t rows[$];
        exp_t e;
        obs_t got;
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 1, 4'h9, 0, 1, 0));
        rows.push_back(r(0, 4'hA, 1, 1, 4'h0, 1, 4'hA, 1, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'hA, 1, 1, 0));
        rows.push_back(r(1, 4'h0, 0, 1, 4'h3, 0, 4'h3, 0, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h3, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("simultaneous[%0d]", i), val: rows[i].e});
            step();
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        exp_t e;
        obs_t got;
        rows.push_back(r(1, 4'h0, 0, 1, 4'hF, 0, 4'hF, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 0, 1, 4'hF, 0, 4'hF, 0, 1, 0));
        rows.push_back(r(1, 4'h0, 1, 0, 4'h0, 0, 4'h0, 0, 1, 1));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0));
        rows.push_back(r(1, 4'h0, 1, 1, 4'h0, 0, 4'h0, 0, 1, 0));
        foreach (rows[i]) begin
            drive(rows[i].s);
            exp_q.push_back('{name: $sformatf("reset_mid[%0d]", i), val: rows[i].e});
            // Rows 1 and 7 assert reset between edges; rows 2 and 8 hold/release it.
            if (i == 1 || i == 7) begin
                #2;
                CLR_bar = 1'b0;
                #1;
            end else begin
                if (i == 3 || i == 8) CLR_bar = 1'b1;
                step();
            end
            got = sample();
            e = exp_q.pop_front();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mar_load();
        test_pointer_wrap();
        test_load_priority();
        test_mode_toggle();
        test_simultaneous();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mar_input_unit

// File: doc/mar_input_unit.md
Name: mar_input_unit

Overview:
Parametrised successor to the SAP-1 input-and-MAR stage. It holds a bus-loaded memory address register (MAR) and a programmer address pointer that can be loaded or auto-incremented. It also synchronises the run/program switch and drives the RAM address from whichever source the synchronised mode selects. It sits between the W bus and the RAM address inputs and supports both run-mode fetch and sequential front-panel programming.

Parameters:
ADDR_WIDTH, 4, width of bus address, programmer address, MAR and RAM address.
SYNC_STAGES, 2, number of flops in the run_or_prog synchroniser; legal values 2..3.

Ports:
CLK  input  1  system clock; all state changes on rising edge.
CLR_bar  input  1  asynchronous active-low reset.
L_M_bar  input  1  active-low MAR load from bus.
bus_address  input  ADDR_WIDTH  address from W bus.
programmer_address  input  ADDR_WIDTH  front-panel address switches.
LD_P_bar  input  1  active-low load of programmer pointer from programmer_address.
INC_P_bar  input  1  active-low increment of programmer pointer.
run_or_prog  input  1  asynchronous mode switch; 1 = run, 0 = program.
address  output  ADDR_WIDTH  RAM address.
run_mode  output  1  synchronised mode; 1 = run.
addr_valid  output  1  address is stable for the current mode.
wrap  output  1  one-cycle pulse when the pointer increments from all-ones to zero.

Behaviour:
- Reset (CLR_bar=0, asynchronous):
  - MAR=0, pointer=0, all synchroniser flops=0, so run_mode=0 (program mode).
  - addr_valid=0, wrap=0, address=0.
  - Release is synchronous in effect: the first state update occurs on the first rising CLK with CLR_bar=1.
- MAR:
  - On a rising edge with L_M_bar=0, MAR<=bus_address. Otherwise MAR holds.
  - MAR loading is independent of mode; it is allowed in program mode.
- Programmer pointer:
  - LD_P_bar=0 gives pointer<=programmer_address.
  - Otherwise, INC_P_bar=0 gives pointer<=pointer+1 modulo 2^ADDR_WIDTH.
  - Load has priority over increment when both are asserted: no increment, no wrap.
  - The pointer updates in either mode.
- wrap:
  - Registered; asserted for exactly the cycle after an increment from all-ones to zero.
  - Zero in every other cycle, including when a load produces zero.
- Mode synchroniser:
  - run_or_prog passes through SYNC_STAGES flops; run_mode is the last stage.
  - Latency from an input change to run_mode is SYNC_STAGES rising edges.
- Address mux (combinational from registers):
  - address = MAR when run_mode=1, else pointer.
- addr_valid:
  - Registered. Cleared to 0 for exactly one cycle after run_mode changes value (settle cycle); otherwise 1.
  - First set to 1 on the first edge after reset release.
- Simultaneous events:
  - A mode change concurrent with MAR load or pointer update: all registers update on the same edge, and address reflects the new mode and new register values.
  - A glitch on run_or_prog shorter than one clock period may or may not propagate; if it propagates, it produces a full-cycle run_mode pulse with addr_valid behaving as above.
- Reset mid-operation:
  - All state clears immediately and asynchronously.
  - A pending wrap pulse is lost.

Decomposition:
- Shared package: MODE_PROG=1'b0 and MODE_RUN=1'b1 constants; default ADDR_WIDTH constant shared with the RAM and PC blocks.
- One sub-module, mar_sync_chain: SYNC_STAGES-deep synchroniser with async active-low clear, reused later for other front-panel switches.
- The MAR, pointer, wrap and addr_valid logic stay in mar_input_unit.

Test Plan:
- Reset, then apply run_or_prog=1:
  - Before any edge: address=0, run_mode=0, addr_valid=0.
  - run_mode=1 after exactly 2 edges.
  - addr_valid=0 for one cycle after that edge, then 1.
- Run mode, bus_address=4'h3, L_M_bar=0 for one edge, then L_M_bar=1 and bus_address=4'hC:
  - address=3 holds.
  - Re-assert L_M_bar for one edge: address=C.
- Program mode, LD_P_bar=0 with programmer_address=4'hE, then INC_P_bar=0 for 3 edges:
  - Pointer/address sequence E, F, 0, 1.
  - wrap high only in the cycle after the F->0 increment.
- LD_P_bar=0 and INC_P_bar=0 together with programmer_address=4'h7 -> pointer=7, wrap=0.
- Program mode, load MAR=4'h5 and pointer=4'h9; toggle run_or_prog 0->1->0:
  - address goes 9 -> 5 -> 9, each change 2 edges after the input change.
  - A one-cycle addr_valid drop accompanies each change.
- Assert CLR_bar=0 mid-increment with pointer=F and INC_P_bar=0:
  - Immediately address=0, wrap=0, run_mode=0.
  - After release with no controls asserted, the pointer stays 0.
